// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush sequencer with mul/div wait FSM.
// Optional stall-cycle counter is enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard_stall,
    input  logic        id_jump_taken,
    input  logic        ex_md_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        exc_flush,
    input  logic        perf_clr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] stall_cnt
);
    localparam logic RUN     = 1'b0;
    localparam logic MD_WAIT = 1'b1;
    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    logic       state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    logic       mem_wait;

    assign mem_wait = mem_req & ~mem_ready;

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_done     = 1'b0;
        if (exc_flush) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            md_cnt_d    = 4'd0;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if ((state_q == RUN && ex_md_start) || (state_q == MD_WAIT && md_cnt_q != 4'd0)) begin
            // EX freezes; EX/MEM receives bubbles until the result is ready
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
            state_d     = MD_WAIT;
            md_cnt_d    = (state_q == RUN) ? MD_LOAD : md_cnt_q - 4'd1;
        end else if (state_q == MD_WAIT) begin
            md_done = 1'b1;
            state_d = RUN;
        end else if (hazard_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_jump_taken) begin
            ifid_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy = (state_q == MD_WAIT);

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = perf_clr ? 32'd0 : (!pc_en && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= 32'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = 32'd0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl (MD_CYCLES=4).
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hazard_stall = 1'b0, id_jump_taken = 1'b0, ex_md_start = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0, exc_flush = 1'b0, perf_clr = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, md_busy, md_done;
    logic [31:0] stall_cnt;
    int          vectors = 0, miscompares = 0;
    logic [31:0] exp_cnt = 32'd0;

    // {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl, busy,done}
    localparam logic [9:0] IDLE  = 10'b11111_000_00;
    localparam logic [9:0] HAZ   = 10'b00111_010_00;
    localparam logic [9:0] JMP   = 10'b11111_100_00;
    localparam logic [9:0] MD0   = 10'b00011_001_00;
    localparam logic [9:0] MDW   = 10'b00011_001_10;
    localparam logic [9:0] REL   = 10'b11111_000_11;
    localparam logic [9:0] MWW   = 10'b00000_000_10;
    localparam logic [9:0] MWR   = 10'b00000_000_00;
    localparam logic [9:0] EXCW  = 10'b11111_111_10;

    pipe_ctrl #(.MD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .hazard_stall(hazard_stall), .id_jump_taken(id_jump_taken),
        .ex_md_start(ex_md_start), .mem_req(mem_req), .mem_ready(mem_ready), .exc_flush(exc_flush),
        .perf_clr(perf_clr), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] outs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, md_busy, md_done};
    endfunction

    // inputs: {hazard, jump, md_start, mem_req, mem_ready, exc, clr}
    task automatic apply(input string tag, input logic [6:0] in, input logic [9:0] exp);
        @(posedge clk);
        #1;
        {hazard_stall, id_jump_taken, ex_md_start, mem_req, mem_ready, exc_flush, perf_clr} = in;
        @(negedge clk);
        check(tag, 32'(outs()), 32'(exp));
        check({tag, "_cnt"}, stall_cnt, exp_cnt);
`ifdef PIPE_CTRL_PERF_EN
        if (in[0]) exp_cnt = 32'd0;
        else if (!exp[9]) exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_outs", 32'(outs()), 32'(IDLE));
        check("rst_cnt", stall_cnt, 32'd0);
        rst_n = 1'b1;
        apply("idle", 7'b0000000, IDLE);
        apply("haz_jmp", 7'b1100000, HAZ);
        apply("idle2", 7'b0000000, IDLE);
        apply("jump", 7'b0100000, JMP);
        apply("md_t0", 7'b0010000, MD0);
        apply("md_t1", 7'b0010000, MDW);
        apply("md_t2", 7'b0110000, MDW);
        apply("md_t3", 7'b0010000, MDW);
        apply("md_t4", 7'b0010000, REL);
        apply("md_t5", 7'b0000000, IDLE);
        apply("mw_t0", 7'b0010000, MD0);
        apply("mw_t1", 7'b0010000, MDW);
        apply("mw_t2", 7'b0011000, MWW);
        apply("mw_t3", 7'b0010000, MDW);
        apply("mw_t4", 7'b0010000, MDW);
        apply("mw_t5", 7'b0010000, REL);
        apply("mw_t6", 7'b0000000, IDLE);
        apply("ex_t0", 7'b0010000, MD0);
        apply("ex_t1", 7'b0010000, MDW);
        apply("ex_t2", 7'b0010010, EXCW);
        apply("ex_t3", 7'b0000000, IDLE);
        apply("memw_run", 7'b1001000, MWR);
        apply("mem_rdy", 7'b1001100, HAZ);
        apply("rh_t0", 7'b0010000, MD0);
        apply("rh_t1", 7'b0000000, MDW);
        apply("rh_t2", 7'b0000000, MDW);
        apply("rh_t3", 7'b0000000, MDW);
        apply("rh_t4", 7'b1110000, REL);
        apply("rh_t5", 7'b1000000, HAZ);
        apply("clr_haz", 7'b1000001, HAZ);
        apply("after_clr", 7'b0000000, IDLE);
        for (int i = 0; i < 10; i++) apply("haz10", 7'b1000000, HAZ);
        apply("haz10_end", 7'b0000000, IDLE);
        apply("ar_t0", 7'b0010000, MD0);
        apply("ar_t1", 7'b0010000, MDW);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(md_busy), 32'd0);
        check("async_cnt", stall_cnt, 32'd0);
        exp_cnt = 32'd0;
        {hazard_stall, id_jump_taken, ex_md_start, mem_req, mem_ready, exc_flush, perf_clr} = 7'b0;
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 7'b0000000, IDLE);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It merges the combinational load-use/branch hazard stall, ID-stage taken jumps, a fixed-latency multi-cycle multiply/divide in EX, data-memory wait states and exception flushes. From these it drives the PC and every pipeline-register enable and flush. It owns the only sequential stall state in the core: the mul/div wait FSM and its cycle counter.

## Interface

Parameters:
- MD_CYCLES, 4: total EX freeze cycles for a mul/div, including the start cycle; legal range 2..15.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- hazard_stall  input  1  ID must hold, from hazard detection (load-use or unresolved branch operand)
- id_jump_taken  input  1  ID resolved a taken jump/branch; the IF instruction is wrong-path
- ex_md_start  input  1  EX holds a mul/div instruction
- mem_req  input  1  MEM stage accesses data memory this cycle
- mem_ready  input  1  data memory completes the access this cycle
- exc_flush  input  1  exception/redirect from MEM; kill IF/ID, ID/EX, EX/MEM
- perf_clr  input  1  synchronous clear of stall_cnt
- pc_en  output  1  PC register load enable
- ifid_en, idex_en, exmem_en, memwb_en  output  1 each  pipeline-register load enables
- ifid_flush, idex_flush, exmem_flush  output  1 each  load a bubble (NOP, all control 0) when the register is enabled
- md_busy  output  1  registered; high while in MD_WAIT
- md_done  output  1  one-cycle pulse on the mul/div release cycle
- stall_cnt  output  32  cycles with pc_en=0 (see Configuration)

## Operation

- States: RUN, MD_WAIT. 4-bit down-counter md_cnt.
- Definition: mem_wait = mem_req & ~mem_ready.
- Enables and flushes are combinational from state, md_cnt and the current inputs. Priority, highest first:
- 1. exc_flush: pc_en=1; all enables=1; ifid/idex/exmem_flush=1; next state RUN; md_cnt←0; mul/div is aborted.
- 2. mem_wait: all enables=0, all flushes=0. State and md_cnt hold; no decrement.
- 3. RUN with ex_md_start: pc_en=ifid_en=idex_en=0, exmem_en=1, exmem_flush=1. md_cnt←MD_CYCLES-1; next state MD_WAIT. hazard_stall and id_jump_taken are ignored.
- 4. MD_WAIT with md_cnt≠0: same freeze as item 3; md_cnt decrements; ex_md_start is ignored.
- 5. MD_WAIT with md_cnt=0 (release): all enables=1, no flush; md_done=1; next state RUN. This cycle is then re-evaluated for items 6–8 on the next edge only; the same cycle never re-triggers item 3.
- 6. RUN with hazard_stall: pc_en=ifid_en=0, idex_en=1, idex_flush=1. A simultaneous id_jump_taken is ignored; ID holds and re-resolves it after the stall.
- 7. RUN with id_jump_taken: all enables=1, ifid_flush=1.
- 8. Otherwise: all enables=1, no flush.
- memwb_en=0 only under mem_wait (exc_flush excepted).

## Timing

- Reset (rst_n=0, async): state RUN, md_cnt=0, md_busy=0, stall_cnt=0. Combinational outputs follow item 8 unless inputs dictate otherwise.
- Mul/div with no memory waits: start cycle T0 plus MD_CYCLES-1 MD_WAIT cycles are frozen. Release and md_done occur at T0+MD_CYCLES.
- Each mem_wait cycle during MD_WAIT extends the freeze by exactly one cycle.
- Hazard stall costs exactly one bubble per asserted cycle; zero added latency otherwise.
- Reset mid-MD_WAIT returns to RUN immediately. exc_flush mid-MD_WAIT returns to RUN at the next edge.
- md_busy is the registered state decode: it rises one cycle after T0 and falls on the edge ending the release cycle.

## Configuration

- PIPE_CTRL_PERF_EN defined: stall_cnt increments each cycle that pc_en=0 and saturates at 0xFFFFFFFF. perf_clr has priority over increment.
- PIPE_CTRL_PERF_EN undefined: no counter flops; stall_cnt tied to 0; perf_clr unused.

## Test plan

- Reset, then idle inputs → all enables=1, flushes=0, md_busy=0, stall_cnt=0.
- hazard_stall=1 and id_jump_taken=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0; stall_cnt=1.
- MD_CYCLES=4, ex_md_start held at T0..T4 → freeze T0..T3, exmem_flush=1 T0..T3, md_done=1 only at T4, md_busy=1 T1..T4.
- Same as previous with mem_req=1, mem_ready=0 at T2 → all enables=0 at T2; md_done moves to T5.
- exc_flush at T2 of a mul/div → T2 has all three flushes=1 and pc_en=1; T3 is in RUN, md_busy=0, no md_done.
- Build without PIPE_CTRL_PERF_EN, run 10 hazard stalls → stall_cnt stays 0.
